// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle instruction / interrupt-entry sequencer for the ATmega32A core.
// Counts each instruction down on clock_counter, arbitrates interrupts at instruction
// boundaries, and steps interrupt_stage through push-PC-low, push-PC-high, load-vector.
// Ports: clk/reset (async, active-high); decoder side instr_valid, instruction_id,
//   branch_taken; sreg_i (global I flag); irq_req[NUM_IRQ]. Outputs clock_counter,
//   interrupt_stage, fetch_en, busy, irq_ack (one-hot pulse), irq_vector (2*index+2),
//   sreg_i_clr (pulse in the load-vector stage).
// Option IRQ_PENDING_LATCH_EN: when defined, rising edges of irq_req are latched as
//   pending flags cleared by their own irq_ack; otherwise irq_req levels are arbitrated.
module cycle_sequencer #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [7:0]         instruction_id,
  input  logic               branch_taken,
  input  logic               sreg_i,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [1:0]         clock_counter,
  output logic [1:0]         interrupt_stage,
  output logic               fetch_en,
  output logic               busy,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [VEC_W-1:0]   irq_vector,
  output logic               sreg_i_clr
);

  typedef enum logic {
    ST_EXEC = 1'b0,
    ST_IRQ  = 1'b1
  } state_t;

  localparam logic [1:0] STG_IDLE   = 2'b00;
  localparam logic [1:0] STG_PUSH_L = 2'b10;
  localparam logic [1:0] STG_PUSH_H = 2'b01;
  localparam logic [1:0] STG_VECTOR = 2'b11;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic [1:0]         r_stage, w_stage_nxt;
  logic [NUM_IRQ-1:0] r_ack, w_ack_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;

  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_win_onehot;
  logic [VEC_W-1:0]   w_win_vec;
  logic               w_boundary;
  logic               w_take;

  // Remaining cycles after the accept cycle (N-1) for a decoded instruction.
  function automatic logic [1:0] f_cnt_load(input logic [7:0] id, input logic taken);
    logic [1:0] n_m1;
    n_m1 = 2'd0;
    case (id)
      8'h2C, 8'h22:                      n_m1 = 2'd2;
      8'h2D, 8'h2E:                      n_m1 = 2'd3;
      8'h2B, 8'h2A, 8'h19, 8'h38, 8'h2F: n_m1 = 2'd1;
      8'h04, 8'h05, 8'h06, 8'h07, 8'h08: n_m1 = taken ? 2'd1 : 2'd0;
      default:                           n_m1 = 2'd0;
    endcase
    return n_m1;
  endfunction

`ifdef IRQ_PENDING_LATCH_EN
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_rise = irq_req & ~r_irq_prev;
  // Include this cycle's rising edge so a pulse landing on the boundary is seen.
  assign w_pend = r_pend | w_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
    end else begin
      r_irq_prev <= irq_req;
      // The ack pulse retires the flag; a fresh edge in the same cycle re-arms it.
      r_pend     <= (r_pend & ~r_ack) | w_rise;
    end
  end
`else
  assign w_pend = irq_req;
`endif

  // Lowest index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    w_win_onehot = '0;
    w_win_vec    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_win_onehot    = '0;
        w_win_onehot[i] = 1'b1;
        w_win_vec       = VEC_W'((i * 2) + 2);
      end
    end
  end

  assign w_boundary = (r_state == ST_EXEC) && (r_cnt == 2'd0);
  assign w_take     = w_boundary && sreg_i && (|w_pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EXEC;
      r_cnt   <= 2'd0;
      r_stage <= STG_IDLE;
      r_ack   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_ack   <= w_ack_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_ack_nxt   = '0;
    w_vec_nxt   = r_vec;
    case (r_state)
      ST_EXEC: begin
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else if (w_take) begin
          // Interrupt beats a same-cycle instruction; the PC is not advanced.
          w_state_nxt = ST_IRQ;
          w_stage_nxt = STG_PUSH_L;
          w_ack_nxt   = w_win_onehot;
          w_vec_nxt   = w_win_vec;
        end else if (instr_valid) begin
          w_cnt_nxt = f_cnt_load(instruction_id, branch_taken);
        end
      end
      ST_IRQ: begin
        case (r_stage)
          STG_PUSH_L: w_stage_nxt = STG_PUSH_H;
          STG_PUSH_H: w_stage_nxt = STG_VECTOR;
          default: begin
            w_stage_nxt = STG_IDLE;
            w_state_nxt = ST_EXEC;
          end
        endcase
      end
      default: w_state_nxt = ST_EXEC;
    endcase
  end

  assign clock_counter   = r_cnt;
  assign interrupt_stage = r_stage;
  // Gated by reset so every output reads 0 while reset is held.
  assign fetch_en        = w_boundary && !w_take && !reset;
  assign busy            = (r_cnt != 2'd0) || (r_state == ST_IRQ);
  assign irq_ack         = r_ack;
  assign irq_vector      = r_vec;
  assign sreg_i_clr      = (r_state == ST_IRQ) && (r_stage == STG_VECTOR);

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;
  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = 12;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [7:0]  instruction_id;
  logic        branch_taken;
  logic        sreg_i;
  logic [7:0]  irq_req;
  logic [1:0]  clock_counter;
  logic [1:0]  interrupt_stage;
  logic        fetch_en;
  logic        busy;
  logic [7:0]  irq_ack;
  logic [11:0] irq_vector;
  logic        sreg_i_clr;

  int n_checks = 0;
  int n_pass   = 0;

  cycle_sequencer #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instruction_id (instruction_id),
    .branch_taken   (branch_taken),
    .sreg_i         (sreg_i),
    .irq_req        (irq_req),
    .clock_counter  (clock_counter),
    .interrupt_stage(interrupt_stage),
    .fetch_en       (fetch_en),
    .busy           (busy),
    .irq_ack        (irq_ack),
    .irq_vector     (irq_vector),
    .sreg_i_clr     (sreg_i_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model: schedule of expected future cycles -------------
  typedef struct packed {
    logic [1:0]  cnt;
    logic [1:0]  stage;
    logic [7:0]  ack;
    logic [11:0] vec;
    logic        clr;
  } rec_t;

  rec_t        sched[$];
  logic [11:0] m_vec;
  logic [7:0]  m_pend;
  logic [7:0]  m_prev;

  function automatic int cycles_of(input logic [7:0] id, input logic bt);
    if (id == 8'h2C || id == 8'h22) return 3;
    if (id == 8'h2D || id == 8'h2E) return 4;
    if (id == 8'h2B || id == 8'h2A || id == 8'h19 || id == 8'h38 || id == 8'h2F) return 2;
    if (id >= 8'h04 && id <= 8'h08) return bt ? 2 : 1;
    return 1;
  endfunction

  always @(negedge clk) begin : compare
    rec_t       r;
    logic [7:0] p;
    logic       take;
    int         idx;
    int         n;
    if (reset) begin
      sched.delete();
      m_vec  = '0;
      m_pend = '0;
      m_prev = '0;
      chk("rst_cnt", clock_counter, 0);
      chk("rst_stage", interrupt_stage, 0);
      chk("rst_fetch", fetch_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", irq_ack, 0);
      chk("rst_vec", irq_vector, 0);
      chk("rst_clr", sreg_i_clr, 0);
    end else begin
`ifdef IRQ_PENDING_LATCH_EN
      m_pend = m_pend | (irq_req & ~m_prev);
      m_prev = irq_req;
      p      = m_pend;
`else
      p      = irq_req;
`endif
      if (sched.size() > 0) begin
        // Mid-instruction or mid-entry cycle: fully determined by the schedule.
        r     = sched.pop_front();
        m_vec = r.vec;
        chk("cnt", clock_counter, r.cnt);
        chk("stage", interrupt_stage, r.stage);
        chk("ack", irq_ack, r.ack);
        chk("vec", irq_vector, r.vec);
        chk("clr", sreg_i_clr, r.clr);
        chk("fetch", fetch_en, 0);
        chk("busy", busy, 1);
      end else begin
        // Instruction boundary.
        take = sreg_i && (p != 8'h00);
        chk("b_cnt", clock_counter, 0);
        chk("b_stage", interrupt_stage, 0);
        chk("b_ack", irq_ack, 0);
        chk("b_vec", irq_vector, m_vec);
        chk("b_clr", sreg_i_clr, 0);
        chk("b_busy", busy, 0);
        chk("b_fetch", fetch_en, !take);
        if (take) begin
          idx = 0;
          while (!p[idx]) idx++;
          sched.push_back('{cnt: 2'd0, stage: 2'b10, ack: (8'd1 << idx), vec: 12'(2 * idx + 2), clr: 1'b0});
          sched.push_back('{cnt: 2'd0, stage: 2'b01, ack: 8'd0, vec: 12'(2 * idx + 2), clr: 1'b0});
          sched.push_back('{cnt: 2'd0, stage: 2'b11, ack: 8'd0, vec: 12'(2 * idx + 2), clr: 1'b1});
          m_pend[idx] = 1'b0;
        end else if (instr_valid) begin
          n = cycles_of(instruction_id, branch_taken);
          for (int c = n - 1; c >= 1; c--)
            sched.push_back('{cnt: 2'(c), stage: 2'b00, ack: 8'd0, vec: m_vec, clr: 1'b0});
        end
      end
    end
  end

  // One clock of stimulus; also models SREG I being cleared by sreg_i_clr.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic bt, input logic [7:0] req);
    logic clr;
    instr_valid    = iv;
    instruction_id = id;
    branch_taken   = bt;
    irq_req        = req;
    @(negedge clk);
    clr = sreg_i_clr;
    @(posedge clk);
    #1;
    if (clr) sreg_i = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction_id = 8'h00;
    branch_taken = 1'b0; sreg_i = 1'b0; irq_req = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("L_rst_fetch", fetch_en, 0);
    chk("L_rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("L_post_rst_fetch", fetch_en, 1);
    chk("L_post_rst_cnt", clock_counter, 0);

    // RCALL: 2,1,0
    cyc(1'b1, 8'h2C, 1'b0, 8'h00);
    chk("L_rcall_c2", clock_counter, 2); chk("L_rcall_busy2", busy, 1); chk("L_rcall_f2", fetch_en, 0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_rcall_c1", clock_counter, 1); chk("L_rcall_busy1", busy, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_rcall_c0", clock_counter, 0); chk("L_rcall_busy0", busy, 0); chk("L_rcall_f0", fetch_en, 1);

    // Branch 0x05 not taken (1 cycle) vs taken (2 cycles)
    cyc(1'b1, 8'h05, 1'b0, 8'h00);
    chk("L_brn_c", clock_counter, 0); chk("L_brn_f", fetch_en, 1);
    cyc(1'b1, 8'h05, 1'b1, 8'h00);
    chk("L_brt_c1", clock_counter, 1); chk("L_brt_f1", fetch_en, 0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_brt_c0", clock_counter, 0); chk("L_brt_f0", fetch_en, 1);

    // RET with irq_req=0110, sreg_i=1; RCALL presented on the boundary is ignored
    sreg_i = 1'b1;
    cyc(1'b1, 8'h2D, 1'b0, 8'h00);
    chk("L_ret_c3", clock_counter, 3);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    chk("L_ret_c0", clock_counter, 0); chk("L_ret_bnd_fetch", fetch_en, 0);
    cyc(1'b1, 8'h2C, 1'b0, 8'h06);
    chk("L_irq_stg2", interrupt_stage, 2'b10); chk("L_irq_ack", irq_ack, 8'h02);
    chk("L_irq_vec", irq_vector, 12'd4); chk("L_irq_cnt", clock_counter, 0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_irq_stg1", interrupt_stage, 2'b01); chk("L_irq_ack_off", irq_ack, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_irq_stg3", interrupt_stage, 2'b11); chk("L_irq_clr", sreg_i_clr, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_irq_stg0", interrupt_stage, 2'b00); chk("L_irq_fetch", fetch_en, 1);
    chk("L_irq_vec_hold", irq_vector, 12'd4);
    cyc(1'b1, 8'h2C, 1'b0, 8'h00);
    chk("L_rcall_again", clock_counter, 2);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);

    // Same request with sreg_i=0: no entry
    cyc(1'b1, 8'h2D, 1'b0, 8'h06);
    chk("L_noirq_c3", clock_counter, 3);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    chk("L_noirq_fetch", fetch_en, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h06);
    chk("L_noirq_ack", irq_ack, 8'h00); chk("L_noirq_stage", interrupt_stage, 0);
    chk("L_noirq_fetch2", fetch_en, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);

    // Short irq_req[3] pulse during LPM
    do_reset();
    sreg_i = 1'b1;
    cyc(1'b1, 8'h22, 1'b0, 8'h00);
    chk("L_lpm_c2", clock_counter, 2);
    cyc(1'b0, 8'h00, 1'b0, 8'h08);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_lpm_c0", clock_counter, 0);
`ifdef IRQ_PENDING_LATCH_EN
    chk("L_pulse_bnd_fetch", fetch_en, 0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_pulse_ack", irq_ack, 8'h08); chk("L_pulse_vec", irq_vector, 12'd8);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_pulse_done", interrupt_stage, 0);
`else
    chk("L_pulse_bnd_fetch", fetch_en, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_pulse_noack", irq_ack, 8'h00); chk("L_pulse_vec", irq_vector, 12'd0);
`endif

    // Reset asserted during interrupt_stage 2'b01
    sreg_i = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 8'h01);
    chk("L_r_stg2", interrupt_stage, 2'b10); chk("L_r_vec", irq_vector, 12'd2);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_r_stg1", interrupt_stage, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("L_ar_cnt", clock_counter, 0); chk("L_ar_stage", interrupt_stage, 0);
    chk("L_ar_fetch", fetch_en, 0); chk("L_ar_busy", busy, 0);
    chk("L_ar_ack", irq_ack, 0); chk("L_ar_vec", irq_vector, 0); chk("L_ar_clr", sreg_i_clr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; sreg_i = 1'b0; irq_req = 8'h00;
    cyc(1'b1, 8'h2C, 1'b0, 8'h00);
    chk("L_after_rst_c2", clock_counter, 2);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_after_rst_c1", clock_counter, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("L_after_rst_f", fetch_en, 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
